// File: rtl/diff_recon_serial.sv
// Bit-serial operand reconstructor: sum = (diff + sub) mod 2^WIDTH, LSB-first, one bit per clock.
// Optional carry-out port enabled by defining DIFF_RECON_OVF_EN.
module diff_recon_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] diff,
    input  logic [WIDTH-1:0] sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum
`ifdef DIFF_RECON_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           st;
    logic [WIDTH-1:0] d_q, s_q, r_q;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             bit_s, carry_n;

    // Full-adder slice on the current LSBs
    assign bit_s   = d_q[0] ^ s_q[0] ^ c_q;
    assign carry_n = (d_q[0] & s_q[0]) | (d_q[0] & c_q) | (s_q[0] & c_q);

    assign in_ready = (st == IDLE);
    assign sum      = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            d_q       <= '0;
            s_q       <= '0;
            r_q       <= '0;
            c_q       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
`ifdef DIFF_RECON_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        d_q <= diff;
                        s_q <= sub;
                        c_q <= 1'b0;
                        cnt <= '0;
                        st  <= RUN;
                    end
                end
                RUN: begin
                    d_q <= {1'b0, d_q[WIDTH-1:1]};
                    s_q <= {1'b0, s_q[WIDTH-1:1]};
                    r_q <= {bit_s, r_q[WIDTH-1:1]};
                    c_q <= carry_n;
                    cnt <= cnt + 1'b1;
                    // Last bit is processed on the same edge that enters DONE
                    if (cnt == CW'(WIDTH - 1)) begin
                        st        <= DONE;
                        out_valid <= 1'b1;
`ifdef DIFF_RECON_OVF_EN
                        ovf       <= carry_n;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
